// File: rtl/sensemi_regs_arb_pkg.sv
// Shared state type and default parameters for the register-bus arbiter.
package sensemi_regs_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_AXI_ADDR_WIDTH = 13;
  localparam int DEF_AXI_DATA_WIDTH = 32;
  localparam int DEF_RD_LATENCY     = 1;

  // Wide enough to preload RD_LATENCY-1 for latencies up to 4.
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sensemi_axi_regs_if.sv
// Register-file access port: one write strobe, one read strobe, fixed-latency read data.
interface sensemi_axi_regs_if #(
  parameter int OFF_W  = 11,
  parameter int DATA_W = 32
) ();

  logic              wren;
  logic [OFF_W-1:0]  wr_offset;
  logic [DATA_W-1:0] wdata;
  logic              rden;
  logic [OFF_W-1:0]  rd_offset;
  logic [DATA_W-1:0] rdata;

  modport master (
    output wren, wr_offset, wdata, rden, rd_offset,
    input  rdata
  );

  modport slave (
    input  wren, wr_offset, wdata, rden, rd_offset,
    output rdata
  );

endinterface

// File: rtl/sensemi_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last granted index and wraps.
module sensemi_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sensemi_regs_arbiter.sv
// Shares one register-file port between NUM_REQ requesters, one transaction in flight.
// state   | meaning
// IDLE    | no transaction; grant a pending requester round-robin
// ISSUE   | drive wren or rden for one cycle from the latched request
// WAIT_RD | count out the read latency, capture rdata on the last cycle
// RESP    | pulse rsp_valid to the granted requester
module sensemi_regs_arbiter
  import sensemi_regs_arb_pkg::*;
#(
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  parameter  int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter  int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter  int RD_LATENCY     = DEF_RD_LATENCY,
  localparam int OFF_W          = AXI_ADDR_WIDTH - ((AXI_DATA_WIDTH / 32) + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ-1:0]                       req_write,
  input  logic [NUM_REQ-1:0][OFF_W-1:0]            req_offset,
  input  logic [NUM_REQ-1:0][AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                     busy,
  sensemi_axi_regs_if.master                       regs
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t              state, state_nxt;
  logic [IDX_W-1:0]        last_idx;
  logic [IDX_W-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]      gnt_onehot;
  logic [NUM_REQ-1:0]      arb_req;
  logic                    gnt_any;
  logic [IDX_W-1:0]        lat_idx;
  logic                    lat_write;
  logic [OFF_W-1:0]        lat_offset;
  logic [AXI_DATA_WIDTH-1:0] lat_wdata;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  // Requests reach the arbiter only while idle and out of reset, so a grant implies IDLE.
  assign arb_req = (state == IDLE && !rst) ? req_valid : '0;

  sensemi_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (arb_req),
    .last  (last_idx),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_idx   <= IDX_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      rsp_rdata  <= '0;
      lat_idx    <= '0;
      lat_write  <= 1'b0;
      lat_offset <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        last_idx   <= gnt_idx;
        lat_idx    <= gnt_idx;
        lat_write  <= req_write[gnt_idx];
        lat_offset <= req_offset[gnt_idx];
        lat_wdata  <= req_wdata[gnt_idx];
      end
      case (state)
        ISSUE:   wait_cnt <= WAIT_CNT_W'(RD_LATENCY - 1);
        WAIT_RD: begin
          if (wait_cnt == '0) rsp_rdata <= regs.rdata;
          else                wait_cnt  <= wait_cnt - WAIT_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    req_ready       = '0;
    rsp_valid       = '0;
    regs.wren       = 1'b0;
    regs.rden       = 1'b0;
    regs.wr_offset  = '0;
    regs.rd_offset  = '0;
    regs.wdata      = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            req_ready = gnt_onehot;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          if (lat_write) begin
            regs.wren      = 1'b1;
            regs.wr_offset = lat_offset;
            regs.wdata     = lat_wdata;
            state_nxt      = RESP;
          end else begin
            regs.rden      = 1'b1;
            regs.rd_offset = lat_offset;
            state_nxt      = WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (wait_cnt == '0) state_nxt = RESP;
        end
        RESP: begin
          rsp_valid[lat_idx] = 1'b1;
          state_nxt          = IDLE;
        end
      endcase
    end
  end

  assign busy = !rst && (state != IDLE);

endmodule

// File: tb/tb_sensemi_regs_arbiter.sv
// Bench for sensemi_regs_arbiter: cycle-level transaction model, round-robin table, corner sequences.
module tb_sensemi_regs_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int OW = AW - ((DW / 32) + 1);

  typedef struct {
    int           first;
    logic [N-1:0] mask;
    logic [N-1:0] exp_ready;
  } rr_vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid, req_write, req_ready, rsp_valid;
  logic [N-1:0][OW-1:0]  req_offset;
  logic [N-1:0][DW-1:0]  req_wdata;
  logic [DW-1:0]         rsp_rdata;
  logic                  busy;

  sensemi_axi_regs_if #(.OFF_W(OW), .DATA_W(DW)) regs_if ();

  sensemi_regs_arbiter #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .regs(regs_if)
  );

  always #5 clk = ~clk;

  // Register-file slave with an L-stage read pipeline; stale stages carry a marker value.
  bit   [DW-1:0] mem [2**OW];
  logic [DW-1:0] rd_pipe [L];
  always @(posedge clk) begin
    if (regs_if.wren) mem[regs_if.wr_offset] <= regs_if.wdata;
    rd_pipe[0] <= regs_if.rden ? mem[regs_if.rd_offset] : 32'hBAD0_0BAD;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign regs_if.rdata = rd_pipe[L-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  bit auto_drop = 1'b1;

  // Transaction model: k counts cycles since the grant.
  bit            m_busy = 1'b0;
  int            m_k, m_g;
  int            m_last = N - 1;
  bit            m_write;
  logic [OW-1:0] m_off;
  logic [DW-1:0] m_wdata, m_rd_exp;
  logic [DW-1:0] m_last_rd = '0;
  bit   [DW-1:0] ref_mem [2**OW];

  int            obs_ready_cyc [N];
  logic [N-1:0]  obs_ready_vec, obs_rsp_vec;
  int            obs_wren_cyc, obs_rden_cyc, obs_rsp_cyc;
  logic [OW-1:0] obs_woff, obs_roff;
  logic [DW-1:0] obs_wdata, obs_rsp_rdata;
  int            n_wren = 0, n_rden = 0, n_rsp = 0;
  int            glog [$];

  rr_vec_t vecs [8];
  int      exp_order [5];
  int      t0, snap_a, snap_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0]  e_ready, e_rsp;
    logic          e_wren, e_rden, e_busy;
    logic [OW-1:0] e_woff, e_roff;
    logic [DW-1:0] e_wdata;
    int            rk, g;
    @(negedge clk);
    e_ready = '0; e_rsp = '0; e_wren = 1'b0; e_rden = 1'b0; e_busy = 1'b0;
    e_woff = '0; e_roff = '0; e_wdata = '0; g = -1;
    rk = m_write ? 2 : 2 + L;
    if (!rst) begin
      if (!m_busy) begin
        g = rr_pick(m_last, req_valid);
        if (g >= 0) e_ready[g] = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (m_k == 1) begin
          if (m_write) begin e_wren = 1'b1; e_woff = m_off; e_wdata = m_wdata; end
          else begin e_rden = 1'b1; e_roff = m_off; end
        end
        if (m_k == rk) begin
          e_rsp[m_g] = 1'b1;
          if (!m_write) m_last_rd = m_rd_exp;
        end
      end
    end
    check("req_ready", req_ready, e_ready);
    check("rsp_valid", rsp_valid, e_rsp);
    check("wren", regs_if.wren, e_wren);
    check("rden", regs_if.rden, e_rden);
    check("wr_offset", regs_if.wr_offset, e_woff);
    check("rd_offset", regs_if.rd_offset, e_roff);
    check("wdata", regs_if.wdata, e_wdata);
    check("busy", busy, e_busy);
    if (!rst) check("rsp_rdata", rsp_rdata, m_last_rd);

    obs_ready_vec = req_ready;
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin obs_ready_cyc[i] = cyc_n; glog.push_back(i); end
    if (regs_if.wren) begin
      obs_wren_cyc = cyc_n; obs_woff = regs_if.wr_offset; obs_wdata = regs_if.wdata; n_wren++;
    end
    if (regs_if.rden) begin obs_rden_cyc = cyc_n; obs_roff = regs_if.rd_offset; n_rden++; end
    if (rsp_valid != '0) begin
      obs_rsp_cyc = cyc_n; obs_rsp_vec = rsp_valid; obs_rsp_rdata = rsp_rdata; n_rsp++;
    end

    if (rst) begin
      m_busy = 1'b0; m_last = N - 1; m_last_rd = '0;
    end else if (g >= 0) begin
      m_busy = 1'b1; m_k = 1; m_g = g; m_last = g;
      m_write = req_write[g]; m_off = req_offset[g]; m_wdata = req_wdata[g];
      if (m_write) ref_mem[m_off] = m_wdata;
      else         m_rd_exp = ref_mem[m_off];
    end else if (m_busy) begin
      if (m_k == rk) m_busy = 1'b0;
      else           m_k++;
    end
    cyc_n++;
    @(posedge clk);
    #1;
    if (g >= 0 && auto_drop) req_valid[g] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit wr, input int off, input logic [DW-1:0] d);
    req_valid[i]  = 1'b1;
    req_write[i]  = wr;
    req_offset[i] = OW'(off);
    req_wdata[i]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) obs_ready_cyc[i] = -1;
    obs_wren_cyc = -1; obs_rden_cyc = -1; obs_rsp_cyc = -1;
    glog.delete();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_offset = '0; req_wdata = '0;

    vecs[0] = '{0, 4'b1111, 4'b0010};
    vecs[1] = '{1, 4'b1111, 4'b0100};
    vecs[2] = '{2, 4'b1111, 4'b1000};
    vecs[3] = '{3, 4'b1111, 4'b0001};
    vecs[4] = '{3, 4'b0110, 4'b0010};
    vecs[5] = '{0, 4'b0001, 4'b0001};
    vecs[6] = '{2, 4'b0011, 4'b0001};
    vecs[7] = '{1, 4'b1001, 4'b1000};
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);

    // Single write from requester 2
    set_req(2, 1'b1, 'h010, 32'hDEAD_BEEF);
    t0 = cyc_n;
    repeat (4) cycle();
    check("wr_ready_cyc", obs_ready_cyc[2], t0);
    check("wr_wren_cyc", obs_wren_cyc, t0 + 1);
    check("wr_offset_val", obs_woff, 11'h010);
    check("wr_data_val", obs_wdata, 32'hDEAD_BEEF);
    check("wr_rsp_cyc", obs_rsp_cyc, t0 + 2);
    check("wr_rsp_vec", obs_rsp_vec, 4'b0100);

    // Read back through requester 1 after requester 0 stores the value
    set_req(0, 1'b1, 'h123, 32'h1234_5678);
    repeat (4) cycle();
    set_req(1, 1'b0, 'h123, '0);
    t0 = cyc_n;
    repeat (6) cycle();
    check("rd_rden_cyc", obs_rden_cyc, t0 + 1);
    check("rd_offset_val", obs_roff, 11'h123);
    check("rd_rsp_cyc", obs_rsp_cyc, t0 + 2 + L);
    check("rd_rsp_vec", obs_rsp_vec, 4'b0010);
    check("rd_rsp_data", obs_rsp_rdata, 32'h1234_5678);

    // Round-robin table: prime last-granted, then offer a mask while idle
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        req_write[i] = 1'b1; req_offset[i] = OW'(32 + i); req_wdata[i] = 32'hC000_0000 + i;
      end
      set_req(vecs[v].first, 1'b1, 16 + v, 32'hA000_0000 + v);
      repeat (3) cycle();
      req_valid = vecs[v].mask;
      cycle();
      check("rr_table", obs_ready_vec, vecs[v].exp_ready);
      req_valid = '0;
      repeat (3) cycle();
    end

    // All requesters held valid from reset
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 'h100 + i, 32'h5500_0000 + i);
    repeat (15) cycle();
    check("rr_order_len", glog.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++)
      if (k < glog.size()) check("rr_order", glog[k], exp_order[k]);
    req_valid = '0;
    auto_drop = 1'b1;
    repeat (4) cycle();

    // Request arriving during WAIT_RD waits for the next IDLE
    do_reset();
    set_req(0, 1'b0, 'h020, '0);
    t0 = cyc_n;
    cycle();
    set_req(3, 1'b1, 'h021, 32'h3333_3333);
    repeat (5) cycle();
    check("late_rsp0_cyc", obs_rsp_cyc, t0 + 2 + L);
    check("late_ready3_cyc", obs_ready_cyc[3], t0 + 3 + L);
    repeat (4) cycle();

    // Reset during WAIT_RD aborts the read
    do_reset();
    set_req(1, 1'b0, 'h030, '0);
    repeat (3) cycle();
    snap_a = n_rsp;
    snap_b = n_rden;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    check("abort_no_rsp", n_rsp, snap_a);
    check("abort_no_rden", n_rden, snap_b);
    set_req(0, 1'b1, 'h031, 32'h0);
    set_req(3, 1'b1, 'h032, 32'h3);
    cycle();
    check("abort_next_grant", obs_ready_vec, 4'b0001);
    req_valid = '0;
    repeat (3) cycle();

    // Requester 1 withdraws before being granted
    do_reset();
    set_req(0, 1'b1, 'h060, 32'h6060_6060);
    t0 = cyc_n;
    cycle();
    set_req(1, 1'b1, 'h040, 32'h4040_4040);
    set_req(2, 1'b1, 'h050, 32'h5050_5050);
    repeat (2) cycle();
    req_valid[1] = 1'b0;
    snap_a = n_wren;
    repeat (4) cycle();
    check("drop_ready2_cyc", obs_ready_cyc[2], t0 + 3);
    check("drop_ready1_never", obs_ready_cyc[1], -1);
    check("drop_wren_count", n_wren - snap_a, 1);
    check("drop_wr_offset", obs_woff, 11'h050);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
        else if (req_valid[i] && $urandom_range(0, 19) == 0)
          req_valid[i] = 1'b0;
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
